// File: rtl/even_seq_pkg.sv
// even_seq_pkg: shared state type, sequence constant and successor function for the even-sequence checker
package even_seq_pkg;
   typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_e;
   localparam logic [2:0] EVEN_MAX = 3'd6;
   function automatic logic [2:0] succ(input logic [2:0] v);
      return (v >= EVEN_MAX) ? 3'd0 : v + 3'd2;
   endfunction
endpackage

// File: rtl/even_seq_checker_phase.sv
// even_phase_decode: combinational one-hot phase of an even 3-bit value, zero for odd values
//   value_i [2:0] value to decode
//   phase_o [3:0] bit k set for value 2k, all zero when value_i is odd
module even_phase_decode (
   input  logic [2:0] value_i,
   output logic [3:0] phase_o
);
   always_comb phase_o = value_i[0] ? 4'b0000 : 4'b0001 << value_i[2:1];
endmodule

// File: rtl/even_seq_checker.sv
// even_seq_checker: locks onto the 0,2,4,6 counter sequence and flags, counts and phases deviations
//   clk, rst            rising-edge clock, synchronous active-high reset
//   count_in [2:0]      counter value under test, sampled when count_valid is high
//   locked              high while in LOCKED
//   err                 one-cycle pulse per mismatching sample in LOCKED
//   err_cnt [ERR_W]     saturating mismatch count
//   wrap_cnt [WRAP_W]   modulo count of correct 6->0 wraps in LOCKED
//   phase [3:0]         one-hot of the last valid sample, zero if it was odd
//   Build option EVEN_SEQ_RESYNC_ON_ZERO_EN: an unexpected 0 in LOCKED resynchronises instead of erroring.
module even_seq_checker #(
   parameter int LOCK_LEN = 4,
   parameter int MISS_MAX = 2,
   parameter int ERR_W    = 8,
   parameter int WRAP_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        count_in,
   input  logic              count_valid,
   output logic              locked,
   output logic              err,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic [3:0]        phase
);
   import even_seq_pkg::*;
   localparam int RUN_W  = $clog2(LOCK_LEN + 2);
   localparam int MISS_W = $clog2(MISS_MAX + 1);
`ifdef EVEN_SEQ_RESYNC_ON_ZERO_EN
   localparam bit RESYNC = 1'b1;
`else
   localparam bit RESYNC = 1'b0;
`endif
   state_e            state_q;
   logic [2:0]        expected_q;
   logic [RUN_W-1:0]  run_q;
   logic [MISS_W-1:0] miss_q;
   logic [3:0]        phase_d;
   logic              match, is_zero, resync;
   even_phase_decode u_dec (.value_i(count_in), .phase_o(phase_d));
   always_comb begin
      match   = count_in == expected_q;
      is_zero = count_in == 3'd0;
      // only reached on a mismatch, so a 0 here always means expected was non-zero
      resync  = RESYNC && is_zero;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= HUNT;
         expected_q <= 3'd0;
         run_q      <= '0;
         miss_q     <= '0;
         locked     <= 1'b0;
         err        <= 1'b0;
         err_cnt    <= '0;
         wrap_cnt   <= '0;
         phase      <= 4'b0000;
      end else begin
         err <= 1'b0;
         if (count_valid) begin
            phase <= phase_d;
            case (state_q)
               HUNT: if (is_zero) begin
                  state_q    <= CONFIRM;
                  expected_q <= 3'd2;
                  run_q      <= RUN_W'(1);
               end
               CONFIRM: if (match) begin
                  run_q      <= run_q + 1'b1;
                  expected_q <= succ(expected_q);
                  // run counts the leading 0, so lock when this match brings it to LOCK_LEN
                  if (run_q >= RUN_W'(LOCK_LEN - 1)) begin
                     state_q <= LOCKED;
                     locked  <= 1'b1;
                     miss_q  <= '0;
                  end
               end else if (is_zero) begin
                  expected_q <= 3'd2;
                  run_q      <= RUN_W'(1);
               end else begin
                  state_q <= HUNT;
                  run_q   <= '0;
               end
               LOCKED: if (match) begin
                  expected_q <= succ(expected_q);
                  miss_q     <= '0;
                  if (expected_q == 3'd0) wrap_cnt <= wrap_cnt + 1'b1;
               end else if (resync) begin
                  expected_q <= 3'd2;
                  miss_q     <= '0;
               end else begin
                  err <= 1'b1;
                  if (!(&err_cnt)) err_cnt <= err_cnt + 1'b1;
                  // an even outlier re-anchors the sequence; an odd one cannot, so keep stepping
                  expected_q <= count_in[0] ? succ(expected_q) : succ(count_in);
                  if (miss_q >= MISS_W'(MISS_MAX - 1)) begin
                     state_q <= HUNT;
                     locked  <= 1'b0;
                     miss_q  <= '0;
                     run_q   <= '0;
                  end else begin
                     miss_q <= miss_q + 1'b1;
                  end
               end
               default: state_q <= HUNT;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_even_seq_checker.sv
// tb_even_seq_checker: directed self-checking bench for even_seq_checker with default parameters
module tb_even_seq_checker;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] count_in = 3'd0;
   logic       count_valid = 1'b0;
   logic       locked, err;
   logic [7:0] err_cnt, wrap_cnt;
   logic [3:0] phase;
   int         checks = 0;
   int         errors = 0;
   even_seq_checker dut (
      .clk(clk), .rst(rst), .count_in(count_in), .count_valid(count_valid),
      .locked(locked), .err(err), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt), .phase(phase)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic drive(input logic [2:0] v, input logic vld);
      count_in    = v;
      count_valid = vld;
      @(posedge clk);
      #1;
   endtask
   task automatic outs(input string tag, input int lk, input int er, input int ec, input int wc, input int ph);
      chk({tag, ".locked"}, int'(locked), lk);
      chk({tag, ".err"}, int'(err), er);
      chk({tag, ".err_cnt"}, int'(err_cnt), ec);
      chk({tag, ".wrap_cnt"}, int'(wrap_cnt), wc);
      chk({tag, ".phase"}, int'(phase), ph);
   endtask
   initial begin
      drive(3'd5, 1'b1);
      drive(3'd0, 1'b1);
      outs("reset", 0, 0, 0, 0, 0);
      rst = 1'b0;
      drive(3'd0, 1'b1); outs("acq0", 0, 0, 0, 0, 1);
      drive(3'd2, 1'b1); outs("acq2", 0, 0, 0, 0, 2);
      drive(3'd4, 1'b1); outs("acq4", 0, 0, 0, 0, 4);
      drive(3'd6, 1'b1); outs("lock6", 1, 0, 0, 0, 8);
      drive(3'd0, 1'b1); outs("wrap1", 1, 0, 0, 1, 1);
      drive(3'd2, 1'b1);
      drive(3'd4, 1'b1);
      drive(3'd6, 1'b1); outs("pre_wrap2", 1, 0, 0, 1, 8);
      drive(3'd0, 1'b1); outs("wrap2", 1, 0, 0, 2, 1);
      drive(3'd2, 1'b1);
      drive(3'd4, 1'b1);
      drive(3'd6, 1'b1);
      drive(3'd0, 1'b1); outs("wrap3", 1, 0, 0, 3, 1);
      drive(3'd2, 1'b1);
      drive(3'd6, 1'b1); outs("inj6", 1, 1, 1, 3, 8);
      drive(3'd0, 1'b1); outs("reanchor0", 1, 0, 1, 4, 1);
      drive(3'd2, 1'b1);
      drive(3'd3, 1'b1); outs("odd3", 1, 1, 2, 4, 0);
      drive(3'd5, 1'b1); outs("odd5_drop", 0, 1, 3, 4, 0);
      drive(3'd2, 1'b1); outs("hunt2", 0, 0, 3, 4, 2);
      drive(3'd0, 1'b1);
      drive(3'd2, 1'b1);
      drive(3'd0, 1'b1); outs("confirm_rezero", 0, 0, 3, 4, 1);
      drive(3'd2, 1'b1);
      drive(3'd4, 1'b1); outs("relock_pending", 0, 0, 3, 4, 4);
      drive(3'd6, 1'b1); outs("relock", 1, 0, 3, 4, 8);
      drive(3'd0, 1'b1); outs("wrap5", 1, 0, 3, 5, 1);
      drive(3'd2, 1'b1);
      drive(3'd4, 1'b1);
      drive(3'd0, 1'b1);
`ifdef EVEN_SEQ_RESYNC_ON_ZERO_EN
      outs("zero_exp6", 1, 0, 3, 5, 1);
`else
      outs("zero_exp6", 1, 1, 4, 5, 1);
`endif
      drive(3'd2, 1'b1);
      chk("post_zero.err", int'(err), 0);
      chk("post_zero.locked", int'(locked), 1);
      drive(3'd7, 1'b0);
      drive(3'd1, 1'b0);
      drive(3'd3, 1'b0);
`ifdef EVEN_SEQ_RESYNC_ON_ZERO_EN
      outs("hold", 1, 0, 3, 5, 2);
`else
      outs("hold", 1, 0, 4, 5, 2);
`endif
      drive(3'd4, 1'b1);
      chk("hold_expected.err", int'(err), 0);
      chk("hold_expected.phase", int'(phase), 4);
      rst = 1'b1;
      drive(3'd6, 1'b1);
      rst = 1'b0;
      outs("midreset", 0, 0, 0, 0, 0);
      drive(3'd2, 1'b1); outs("after_reset", 0, 0, 0, 0, 2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
